// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FSM states, field widths and IEEE-754 field helpers for the FP add/sub unit
package fp_pkg;

  // Sequencing states of the multi-cycle adder
  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } fp_state_e;

  // Guard, round and sticky bits carried below the fraction
  localparam int GRS_W = 3;
  // Widest operand the helpers below can decode
  localparam int FP_MAX_W = 64;

  // All-ones mask of an exponent field
  function automatic logic [FP_MAX_W-1:0] fp_exp_mask(input int exp_w);
    return (64'd1 << exp_w) - 64'd1;
  endfunction

  // All-ones mask of a fraction field
  function automatic logic [FP_MAX_W-1:0] fp_frac_mask(input int man_w);
    return (64'd1 << man_w) - 64'd1;
  endfunction

  // Positive infinity: exponent all ones, fraction zero
  function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_w, input int man_w);
    return fp_exp_mask(exp_w) << man_w;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set
  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic is_nan(input logic [FP_MAX_W-1:0] x, input int exp_w, input int man_w);
    return (((x >> man_w) & fp_exp_mask(exp_w)) == fp_exp_mask(exp_w)) &&
           ((x & fp_frac_mask(man_w)) != 64'd0);
  endfunction

  function automatic logic is_inf(input logic [FP_MAX_W-1:0] x, input int exp_w, input int man_w);
    return (((x >> man_w) & fp_exp_mask(exp_w)) == fp_exp_mask(exp_w)) &&
           ((x & fp_frac_mask(man_w)) == 64'd0);
  endfunction

  // Zero exponent means zero here: subnormals are flushed to signed zero
  function automatic logic is_zero(input logic [FP_MAX_W-1:0] x, input int exp_w, input int man_w);
    return ((x >> man_w) & fp_exp_mask(exp_w)) == 64'd0;
  endfunction

endpackage

// File: rtl/fp_addsub_seq_if.sv
// rtl/fp_addsub_seq_if.sv - operand issue / result writeback handshake bundle of the FP adder
interface fp_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int XLEN = 1 + EXP_W + MAN_W;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            op_sub;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            overflow;
  logic            underflow;
  logic            invalid;
  logic            busy;

  // Issue side: drives operands, consumes results
  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, invalid, busy
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, result, overflow, underflow, invalid, busy
  );
endinterface

// File: rtl/fp_align_shifter.sv
// rtl/fp_align_shifter.sv - right shifter that collapses all shifted-out bits into a sticky LSB
module fp_align_shifter #(
  parameter int W       = 27,
  parameter int SHIFT_W = 8
) (
  input  logic [W-1:0]       data_i,
  input  logic [SHIFT_W-1:0] shamt_i,
  output logic [W-1:0]       data_o
);

  logic [W-1:0] shifted;
  logic [W-1:0] lost_mask;
  logic         sticky;

  // Shift right; anything that falls off the bottom is ORed into bit 0
  always_comb begin
    shifted   = '0;
    lost_mask = '1;
    if (32'(shamt_i) < 32'(W)) begin
      shifted   = data_i >> shamt_i;
      lost_mask = ~({W{1'b1}} << shamt_i);
    end
    sticky = |(data_i & lost_mask);
    data_o = {shifted[W-1:1], shifted[0] | sticky};
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle handshaked floating-point add/subtract with RNE rounding
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic           clk,
  input  logic           rst,
  fp_addsub_seq_if.slave io
);

  localparam int XLEN = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 1 + GRS_W;  // hidden + frac + G + R + S
  localparam int SW   = MW + 1;             // plus carry-out
  localparam int EW   = EXP_W + 1;          // headroom for carry/round exponent bumps

  localparam logic [XLEN-1:0] QNAN     = XLEN'(fp_qnan(EXP_W, MAN_W));
  localparam logic [XLEN-2:0] INF_MAG  = (XLEN-1)'(fp_inf(EXP_W, MAN_W));
  localparam logic [EW-1:0]   EXP_ONE  = EW'(1);
  localparam logic [EW-1:0]   EXP_MAX  = {1'b0, {EXP_W{1'b1}}};

  fp_state_e       state_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;          // b with the op_sub-adjusted (effective) sign
  logic            sign_q;
  logic            eff_sub_q;
  logic [EW-1:0]   exp_q;
  logic [MW-1:0]   big_q;
  logic [MW-1:0]   small_q;
  logic [SW-1:0]   sum_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            overflow_q;
  logic            underflow_q;
  logic            invalid_q;

  // ---- accept-time special decode ----
  logic [XLEN-1:0] b_eff_d;
  logic            nan_d;
  logic            inf_a_d;
  logic            inf_b_d;

  assign b_eff_d = {io.b[XLEN-1] ^ io.op_sub, io.b[XLEN-2:0]};
  assign nan_d   = is_nan(64'(io.a), EXP_W, MAN_W) | is_nan(64'(b_eff_d), EXP_W, MAN_W);
  assign inf_a_d = is_inf(64'(io.a), EXP_W, MAN_W);
  assign inf_b_d = is_inf(64'(b_eff_d), EXP_W, MAN_W);

  // ---- ALIGN: order by magnitude and align the smaller mantissa ----
  logic [EXP_W-1:0] exp_a, exp_b, exp_big_d, exp_small_d, exp_diff_d;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic [MW-1:0]    mant_a, mant_b, mant_big_d, mant_small_d, small_aligned_d;
  logic             a_ge_b;

  assign exp_a  = a_q[XLEN-2 -: EXP_W];
  assign exp_b  = b_q[XLEN-2 -: EXP_W];
  // Subnormals compare and add as zero
  assign frac_a = is_zero(64'(a_q), EXP_W, MAN_W) ? '0 : a_q[MAN_W-1:0];
  assign frac_b = is_zero(64'(b_q), EXP_W, MAN_W) ? '0 : b_q[MAN_W-1:0];
  assign mant_a = (exp_a == '0) ? '0 : {1'b1, frac_a, {GRS_W{1'b0}}};
  assign mant_b = (exp_b == '0) ? '0 : {1'b1, frac_b, {GRS_W{1'b0}}};
  assign a_ge_b = {exp_a, frac_a} >= {exp_b, frac_b};

  assign exp_big_d    = a_ge_b ? exp_a  : exp_b;
  assign exp_small_d  = a_ge_b ? exp_b  : exp_a;
  assign mant_big_d   = a_ge_b ? mant_a : mant_b;
  assign mant_small_d = a_ge_b ? mant_b : mant_a;
  assign exp_diff_d   = exp_big_d - exp_small_d;

  fp_align_shifter #(
    .W       (MW),
    .SHIFT_W (EXP_W)
  ) u_align_shifter (
    .data_i  (mant_small_d),
    .shamt_i (exp_diff_d),
    .data_o  (small_aligned_d)
  );

  // ---- ADD: magnitude add/subtract; big >= small so subtraction never goes negative ----
  logic [SW-1:0] sum_d;
  assign sum_d = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                           : ({1'b0, big_q} + {1'b0, small_q});

  // ---- ROUND: nearest-even on the normalized sum ----
  logic             round_up_d;
  logic [MAN_W:0]   frac_inc_d;
  logic [EW-1:0]    exp_rnd_d;
  logic             ovf_d;

  assign round_up_d = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
  assign frac_inc_d = {1'b0, sum_q[SW-3:3]} + {{MAN_W{1'b0}}, round_up_d};
  // A fraction carry means 1.111..1 rounded to 10.000..0: bump exponent, fraction wraps to 0
  assign exp_rnd_d  = frac_inc_d[MAN_W] ? exp_q + EXP_ONE : exp_q;
  assign ovf_d      = exp_rnd_d >= EXP_MAX;

  // Sequencer: single operation in flight, outputs registered and held in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_q       <= '0;
      big_q       <= '0;
      small_q     <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            a_q         <= io.a;
            b_q         <= b_eff_d;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            invalid_q   <= 1'b0;
            if (nan_d) begin
              result_q    <= QNAN;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (inf_a_d && inf_b_d && (io.a[XLEN-1] != b_eff_d[XLEN-1])) begin
              result_q    <= QNAN;
              invalid_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (inf_a_d) begin
              result_q    <= {io.a[XLEN-1], INF_MAG};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (inf_b_d) begin
              result_q    <= {b_eff_d[XLEN-1], INF_MAG};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= ALIGN;
            end
          end
        end
        ALIGN: begin
          sign_q    <= a_ge_b ? a_q[XLEN-1] : b_q[XLEN-1];
          eff_sub_q <= a_q[XLEN-1] ^ b_q[XLEN-1];
          exp_q     <= {1'b0, exp_big_d};
          big_q     <= mant_big_d;
          small_q   <= small_aligned_d;
          state_q   <= ADD;
        end
        ADD: begin
          if (sum_d == '0) begin
            // Exact zero is +0 unless both effective operands were negative
            result_q    <= {a_q[XLEN-1] & b_q[XLEN-1], {(XLEN-1){1'b0}}};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (sum_d[SW-1]) begin
            sum_q   <= {1'b0, sum_d[SW-1:2], sum_d[1] | sum_d[0]};
            exp_q   <= exp_q + EXP_ONE;
            state_q <= NORM;
          end else begin
            sum_q   <= sum_d;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (sum_q[SW-2]) begin
            state_q <= ROUND;
          end else if (exp_q > EXP_ONE) begin
            sum_q <= sum_q << 1;
            exp_q <= exp_q - EXP_ONE;
          end else begin
            result_q    <= {sign_q, {(XLEN-1){1'b0}}};
            underflow_q <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        ROUND: begin
          if (ovf_d) begin
            result_q   <= {sign_q, INF_MAG};
            overflow_q <= 1'b1;
          end else begin
            result_q <= {sign_q, exp_rnd_d[EXP_W-1:0], frac_inc_d[MAN_W-1:0]};
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.busy      = (state_q != IDLE);
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.overflow  = overflow_q;
  assign io.underflow = underflow_q;
  assign io.invalid   = invalid_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb/tb_fp_addsub_seq.sv - table-driven scoreboard bench for fp_addsub_seq
module tb_fp_addsub_seq;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp_addsub_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) io ();

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flags;   // {overflow, underflow, invalid}
    int          lat;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[22];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Issue one operation, wait (bounded) for the result, score it and handshake
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] res, input logic [2:0] fl, input int lat,
                        input string tag);
    exp_t e;
    int   n;
    @(negedge clk);
    io.a        = a;
    io.b        = b;
    io.op_sub   = op;
    io.in_valid = 1'b1;
    sb.push_back('{res: res, flags: fl});
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    n = 1;
    while (!io.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    if (io.out_valid) begin
      e = sb.pop_front();
      check({tag, " result"}, io.result, e.res);
      check({tag, " flags"}, {29'd0, io.overflow, io.underflow, io.invalid}, {29'd0, e.flags});
      @(posedge clk);
      #1;
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;

    vecs = '{
      '{32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 3'b000,  5},
      '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000, 28},
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000,  3},
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000,  5},
      '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b000,  5},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100,  5},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001,  1},
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000,  1},
      '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000,  1},
      '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000,  1},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000,  3},
      '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000,  3},
      '{32'h40000000, 32'hC0000000, 1'b0, 32'h00000000, 3'b000,  3},
      '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010,  4},
      '{32'h01000001, 32'h01000000, 1'b1, 32'h00000000, 3'b010,  5},
      '{32'h3F800000, 32'hBF400000, 1'b0, 32'h3E800000, 3'b000,  7},
      '{32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 3'b000,  5},
      '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000,  5},
      '{32'hC0000000, 32'hC0000000, 1'b0, 32'hC0800000, 3'b000,  5},
      '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b000,  5},
      '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000,  6},
      '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000,  5}
    };

    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.op_sub    = 1'b0;
    io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", 32'(io.out_valid), 32'd0);
    check("reset result", io.result, 32'd0);
    check("reset flags", {29'd0, io.overflow, io.underflow, io.invalid}, 32'd0);
    check("reset in_ready", 32'(io.in_ready), 32'd1);
    check("reset busy", 32'(io.busy), 32'd0);

    for (int i = 0; i < 22; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flags, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // Backpressure: result held, new operands refused while DONE waits
    io.out_ready = 1'b0;
    @(negedge clk);
    io.a        = 32'h3FC00000;
    io.b        = 32'h40200000;
    io.op_sub   = 1'b0;
    io.in_valid = 1'b1;
    sb.push_back('{res: 32'h40800000, flags: 3'b000});
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    n = 1;
    while (!io.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp latency", 32'(n), 32'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      io.a        = 32'h3F800000;
      io.b        = 32'h3F800000;
      io.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("bp hold%0d out_valid", c), 32'(io.out_valid), 32'd1);
      check($sformatf("bp hold%0d result", c), io.result, 32'h40800000);
      check($sformatf("bp hold%0d flags", c), {29'd0, io.overflow, io.underflow, io.invalid}, 32'd0);
      check($sformatf("bp hold%0d in_ready", c), 32'(io.in_ready), 32'd0);
    end
    @(negedge clk);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    e = sb.pop_front();
    check("bp result", io.result, e.res);
    @(posedge clk);
    #1;
    check("bp out_valid after handshake", 32'(io.out_valid), 32'd0);
    check("bp in_ready after handshake", 32'(io.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp ignored op busy", 32'(io.busy), 32'd0);

    // Reset in the middle of a long normalization
    @(negedge clk);
    io.a        = 32'h3F800001;
    io.b        = 32'h3F800000;
    io.op_sub   = 1'b1;
    io.in_valid = 1'b1;
    sb.push_back('{res: 32'h34000000, flags: 3'b000});
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid-norm busy", 32'(io.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async reset busy", 32'(io.busy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset out_valid", 32'(io.out_valid), 32'd0);
    check("post-reset result", io.result, 32'd0);
    check("post-reset flags", {29'd0, io.overflow, io.underflow, io.invalid}, 32'd0);
    check("post-reset in_ready", 32'(io.in_ready), 32'd1);
    run_op(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 5, "after-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
